// File: rtl/mem_copy_engine.sv
// Word-by-word copy engine for a single-port synchronous memory.
// Alternates READ/WRITE per word and sums the copied words into a checksum.
`timescale 1ns/1ps
module mem_copy_engine #(
  parameter int ADDRWIDTH = 12,
  parameter int DATAWIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDRWIDTH-1:0] src,
  input  logic [ADDRWIDTH-1:0] dst,
  input  logic [ADDRWIDTH:0]   len,
  output logic                 busy,
  output logic                 done,
  output logic [DATAWIDTH-1:0] checksum,
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic [DATAWIDTH-1:0] mem_d,
  output logic                 mem_load,
  input  logic [DATAWIDTH-1:0] mem_q
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDRWIDTH-1:0]   src_ptr_q, src_ptr_d;
  logic [ADDRWIDTH-1:0]   dst_ptr_q, dst_ptr_d;
  logic [ADDRWIDTH:0]     remain_q, remain_d;
  logic [DATAWIDTH-1:0]   checksum_q, checksum_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      src_ptr_q  <= '0;
      dst_ptr_q  <= '0;
      remain_q   <= '0;
      checksum_q <= '0;
    end else begin
      state_q    <= state_d;
      src_ptr_q  <= src_ptr_d;
      dst_ptr_q  <= dst_ptr_d;
      remain_q   <= remain_d;
      checksum_q <= checksum_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    src_ptr_d  = src_ptr_q;
    dst_ptr_d  = dst_ptr_q;
    remain_d   = remain_q;
    checksum_d = checksum_q;
    mem_addr   = '0;
    mem_d      = '0;
    mem_load   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          src_ptr_d  = src;
          dst_ptr_d  = dst;
          remain_d   = len;
          checksum_d = '0;
          state_d    = (len != '0) ? READ : DONE;
        end
      end
      READ: begin
        mem_addr = src_ptr_q;
        state_d  = WRITE;
      end
      WRITE: begin
        // mem_q holds the word addressed during the preceding READ
        mem_addr   = dst_ptr_q;
        mem_d      = mem_q;
        mem_load   = 1'b1;
        checksum_d = checksum_q + mem_q;
        src_ptr_d  = src_ptr_q + ADDRWIDTH'(1);
        dst_ptr_d  = dst_ptr_q + ADDRWIDTH'(1);
        remain_d   = remain_q - (ADDRWIDTH+1)'(1);
        state_d    = (remain_q != (ADDRWIDTH+1)'(1)) ? READ : DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy     = (state_q == READ) || (state_q == WRITE);
  assign done     = (state_q == DONE);
  assign checksum = checksum_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: behavioural memory, reference copy model,
// and queues of expected writes and checksums.
`timescale 1ns/1ps
module tb_mem_copy_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [11:0] src = '0;
  logic [11:0] dst = '0;
  logic [12:0] len = '0;
  logic        busy;
  logic        done;
  logic [15:0] checksum;
  logic [11:0] mem_addr;
  logic [15:0] mem_d;
  logic        mem_load;
  logic [15:0] mem_q = '0;

  int n_checks = 0;
  int n_err = 0;

  logic [15:0] mem [4096];
  logic [15:0] ref_mem [4096];
  logic [27:0] wq [$];
  logic [15:0] cq [$];

  mem_copy_engine #(.ADDRWIDTH(12), .DATAWIDTH(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .src      (src),
    .dst      (dst),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .checksum (checksum),
    .mem_addr (mem_addr),
    .mem_d    (mem_d),
    .mem_load (mem_load),
    .mem_q    (mem_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_load) mem[mem_addr] <= mem_d;
    mem_q <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_load) begin
      if (wq.size() == 0) begin
        check("unexpected_write", {20'd0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        logic [27:0] e;
        e = wq.pop_front();
        check("wr_addr", {20'd0, mem_addr}, {20'd0, e[27:16]});
        check("wr_data", {16'd0, mem_d}, {16'd0, e[15:0]});
      end
    end
    if (done) begin
      if (cq.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [15:0] c;
        c = cq.pop_front();
        check("checksum", {16'd0, checksum}, {16'd0, c});
      end
    end
  end

  task automatic verify(input logic [11:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      logic [11:0] a;
      a = base + 12'(i);
      check("mem", {16'd0, mem[a]}, {16'd0, ref_mem[a]});
    end
  endtask

  task automatic run_copy(input logic [11:0] s, input logic [11:0] d,
                          input logic [12:0] l, input int rst_word,
                          input bit stray);
    logic [15:0] sum;
    int nw;
    int cyc;
    int busy_n;
    bit fin;
    sum = '0;
    nw = (rst_word >= 0) ? rst_word : int'(l);
    for (int i = 0; i < int'(l); i++) begin
      logic [11:0] a;
      logic [11:0] b;
      logic [15:0] w;
      a = s + 12'(i);
      b = d + 12'(i);
      w = ref_mem[a];
      sum += w;
      if (i < nw) begin
        ref_mem[b] = w;
        wq.push_back({b, w});
      end
    end
    if (rst_word < 0) cq.push_back(sum);

    @(negedge clk);
    start = 1'b1;
    src = s;
    dst = d;
    len = l;
    @(posedge clk);
    #1;
    start = 1'b0;
    src = 12'($urandom);
    dst = 12'($urandom);
    cyc = 0;
    busy_n = 0;
    fin = 1'b0;
    while (!fin && cyc <= 2 * int'(l) + 6) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        check("done_cycle", 32'(cyc), 32'(2 * int'(l)));
        fin = 1'b1;
      end else begin
        if (stray && cyc == 2) begin
          start = 1'b1;
          src = 12'h555;
          dst = 12'h666;
          len = 13'd5;
        end else begin
          start = 1'b0;
        end
        @(posedge clk);
        cyc++;
        if (rst_word >= 0 && cyc == 2 * rst_word + 1) begin
          #2 reset = 1'b1;
          #1;
          check("rst_mem_load", {31'd0, mem_load}, 32'd0);
          check("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
          check("rst_busy", {31'd0, busy}, 32'd0);
          check("rst_done", {31'd0, done}, 32'd0);
          check("rst_checksum", {16'd0, checksum}, 32'd0);
          @(negedge clk);
          reset = 1'b0;
          fin = 1'b1;
        end
      end
    end
    start = 1'b0;
    if (rst_word < 0) begin
      if (!done) check("done_seen", 32'd0, 32'd1);
      check("busy_cycles", 32'(busy_n), 32'(2 * int'(l)));
      @(posedge clk);
      #1;
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_done", {31'd0, done}, 32'd0);
      check("held_checksum", {16'd0, checksum}, {16'd0, sum});
    end
    check("writes_pending", 32'(wq.size()), 32'd0);
    check("sums_pending", 32'(cq.size()), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 16'(i);
      ref_mem[i] = 16'(i);
    end
    #12;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_checksum", {16'd0, checksum}, 32'd0);
    check("reset_mem_load", {31'd0, mem_load}, 32'd0);
    check("reset_mem_addr", {20'd0, mem_addr}, 32'd0);
    check("reset_mem_d", {16'd0, mem_d}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_copy(12'h010, 12'h100, 13'd4, -1, 1'b0);
    verify(12'h0FF, 6);
    check("basic_word0", {16'd0, mem[12'h100]}, 32'h0010);
    check("basic_word3", {16'd0, mem[12'h103]}, 32'h0013);

    run_copy(12'hFFE, 12'h200, 13'd4, -1, 1'b0);
    verify(12'h1FF, 6);
    check("wrap_word1", {16'd0, mem[12'h201]}, 32'h0FFF);
    check("wrap_word2", {16'd0, mem[12'h202]}, 32'h0000);

    run_copy(12'h050, 12'h400, 13'd0, -1, 1'b0);
    verify(12'h400, 4);

    run_copy(12'h000, 12'h001, 13'd3, -1, 1'b0);
    verify(12'h000, 5);
    check("overlap_word3", {16'd0, mem[12'h003]}, 32'h0000);

    run_copy(12'h020, 12'h300, 13'd8, 2, 1'b0);
    verify(12'h2FF, 10);
    check("rst_word1", {16'd0, mem[12'h301]}, 32'h0021);
    check("rst_word2", {16'd0, mem[12'h302]}, 32'h0302);

    run_copy(12'h010, 12'h100, 13'd4, -1, 1'b1);
    verify(12'h0FF, 6);
    verify(12'h555, 5);
    verify(12'h666, 5);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
